// File: rtl/cellrv32_npu_pkg.sv
// cellrv32_npu_pkg: shared NPU arbiter types
package cellrv32_npu_pkg;
  typedef enum logic {IDLE, BURST} npu_arb_state_t;
endpackage

// File: rtl/cellrv32_npu_rr_pick.sv
// cellrv32_npu_rr_pick: first set request scanning upward from ptr+1, wrapping
module cellrv32_npu_rr_pick #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         valid
);
  logic [W-1:0] k;
  always_comb begin
    idx = '0;
    valid = 1'b0;
    k = '0;
    for (int o = N; o >= 1; o--) begin
      k = W'((int'(ptr) + o) % N);
      if (req[k]) begin
        idx = k;
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cellrv32_npu_fifo_arb.sv
// cellrv32_npu_fifo_arb: round-robin burst arbiter feeding one FIFO write port with its own occupancy count
module cellrv32_npu_fifo_arb
  import cellrv32_npu_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 32,
  parameter int MAX_BURST  = 8
) (
  input  logic                              clk_i,
  input  logic                              rstn_i,
  input  logic [NUM_REQ-1:0]                req_i,
  input  logic [NUM_REQ*DATA_W-1:0]         data_i,
  input  logic [NUM_REQ-1:0]                last_i,
  output logic [NUM_REQ-1:0]                ack_o,
  output logic [DATA_W-1:0]                 fifo_data_o,
  output logic                              fifo_we_o,
  input  logic                              fifo_rd_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level_o,
  output logic [$clog2(NUM_REQ)-1:0]        owner_o,
  output logic                              busy_o
);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int OWN_W = $clog2(NUM_REQ);
  localparam int BC_W  = $clog2(MAX_BURST + 1);
  localparam logic [LVL_W-1:0] FULL   = LVL_W'(FIFO_DEPTH);
  localparam logic [BC_W-1:0]  BC_END = BC_W'(MAX_BURST - 1);
  npu_arb_state_t state_q, state_d;
  logic [OWN_W-1:0] owner_q, owner_d, ptr_q, ptr_d, pick_idx;
  logic [BC_W-1:0]  bcnt_q, bcnt_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             pick_valid, wr, rd_eff;
  cellrv32_npu_rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (req_i),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );
  always_comb begin
    wr = (state_q == BURST) && req_i[owner_q] && (level_q < FULL);
    rd_eff = fifo_rd_i && (level_q != '0);
    level_d = level_q + LVL_W'(wr) - LVL_W'(rd_eff);
    fifo_we_o = wr;
    fifo_data_o = '0;
    ack_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (wr && owner_q == OWN_W'(k)) begin
        ack_o[k] = 1'b1;
        fifo_data_o = data_i[k*DATA_W +: DATA_W];
      end
    end
    state_d = state_q;
    owner_d = owner_q;
    ptr_d = ptr_q;
    bcnt_d = bcnt_q;
    if (state_q == IDLE) begin
      if (pick_valid) begin
        state_d = BURST;
        owner_d = pick_idx;
        bcnt_d = '0;
      end
    end else begin
      bcnt_d = wr ? bcnt_q + BC_W'(1) : bcnt_q;
      if ((wr && (last_i[owner_q] || bcnt_q == BC_END)) || !req_i[owner_q]) begin
        state_d = IDLE;
        ptr_d = owner_q;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q <= OWN_W'(NUM_REQ - 1);
      bcnt_q <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q <= ptr_d;
      bcnt_q <= bcnt_d;
      level_q <= level_d;
    end
  end
  assign level_o = level_q;
  assign owner_o = owner_q;
  assign busy_o  = (state_q == BURST);
endmodule

// File: tb/tb_cellrv32_npu_fifo_arb.sv
// tb_cellrv32_npu_fifo_arb: directed and random checks against a grant/level reference model
module tb_cellrv32_npu_fifo_arb;
  localparam int N = 4, DW = 8, D = 32, MB = 8;
  logic clk = 1'b0, rstn = 1'b0, rd = 1'b0;
  logic [N-1:0] req = '0, last = '0, ack, mack = '0;
  logic [N*DW-1:0] data = '0;
  logic [DW-1:0] fdata;
  logic we, busy;
  logic [5:0] level;
  logic [1:0] owner;
  int checks = 0, failures = 0;
  int g, p, o, lv, n, cnt, cnt0, rdp;
  always #5 clk = ~clk;
  cellrv32_npu_fifo_arb #(.NUM_REQ(N), .DATA_W(DW), .FIFO_DEPTH(D), .MAX_BURST(MB)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .req_i       (req),
    .data_i      (data),
    .last_i      (last),
    .ack_o       (ack),
    .fifo_data_o (fdata),
    .fifo_we_o   (we),
    .fifo_rd_i   (rd),
    .level_o     (level),
    .owner_o     (owner),
    .busy_o      (busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  task automatic mreset();
    g = -1; p = N - 1; o = 0; lv = 0; n = 0; mack = '0;
  endtask
  task automatic set_word(input int k, input logic [DW-1:0] d, input logic l);
    data[k*DW +: DW] = d;
    last[k] = l;
  endtask
  task automatic step();
    bit w;
    #1;
    w = g >= 0 && req[g] && lv < D;
    mack = w ? N'(1) << g : '0;
    chk("ack", ack, mack);
    chk("we", we, w);
    chk("data", fdata, w ? data[g*DW +: DW] : '0);
    chk("level", level, lv);
    chk("owner", owner, o);
    chk("busy", busy, g >= 0);
    @(posedge clk);
    lv = lv + int'(w) - int'(rd && lv > 0);
    if (g < 0) begin
      for (int i = 1; i <= N; i++)
        if (g < 0 && req[(p + i) % N]) begin g = (p + i) % N; o = g; n = 0; end
    end else begin
      n += int'(w);
      if ((w && (last[g] || n == MB)) || !req[g]) begin p = g; g = -1; end
    end
    @(negedge clk);
  endtask
  initial begin
    mreset();
    @(negedge clk); @(negedge clk);
    step();
    rstn = 1'b1;
    req = 4'b0100; set_word(2, 8'hA1, 1'b0);
    step();
    chk("single_owner", owner, 2);
    chk("single_busy", busy, 1);
    for (int i = 1; i <= 3; i++) begin
      set_word(2, 8'(160 + i), i == 3);
      #1 chk("single_ack", ack, 4'b0100);
      step();
    end
    chk("single_level", level, 3);
    chk("single_idle", busy, 0);
    req = '0; last = '0;
    rstn = 1'b0; mreset(); step(); rstn = 1'b1;
    req = 4'hF; data = 32'h44332211; rd = 1'b1; cnt = 0; cnt0 = 0;
    repeat (45) begin #1 cnt += $countones(ack); cnt0 += int'(ack[0]); step(); end
    chk("fair_total", cnt, 40);
    chk("fair_p0", cnt0, 16);
    req = '0;
    repeat (3) step();
    rd = 1'b0; req = 4'b0010; set_word(1, 8'h5A, 1'b0); cnt = 0;
    repeat (45) begin #1 cnt += $countones(ack); step(); end
    chk("stall_acks", cnt, 32);
    chk("stall_level", level, 32);
    chk("stall_busy", busy, 1);
    rd = 1'b1;
    #1 chk("stall_noack", ack, 0);
    step();
    rd = 1'b0;
    chk("stall_lvl31", level, 31);
    cnt = 0;
    repeat (4) begin #1 cnt += $countones(ack); step(); end
    chk("stall_one", cnt, 1);
    req = '0; rd = 1'b1;
    repeat (27) step();
    chk("sim_pre", level, 5);
    req = 4'b0010; rd = 1'b0; step();
    rd = 1'b1; step();
    chk("sim_level", level, 5);
    req = '0;
    repeat (6) step();
    chk("empty_level", level, 0);
    step();
    chk("underflow", level, 0);
    rd = 1'b0;
    req = 4'b1001; set_word(3, 8'hC3, 1'b0); set_word(0, 8'h0F, 1'b0);
    step();
    chk("drop_owner", owner, 3);
    repeat (2) step();
    req = 4'b0001; step();
    chk("drop_idle", busy, 0);
    step();
    chk("drop_next", owner, 0);
    chk("drop_busy", busy, 1);
    for (int i = 0; i < 40 && !(level == 10 && busy); i++) step();
    chk("rst_reach10", {busy, level}, {1'b1, 6'd10});
    #2 rstn = 1'b0;
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_we", we, 0);
    chk("rst_data", fdata, 0);
    chk("rst_level", level, 0);
    chk("rst_owner", owner, 0);
    chk("rst_busy", busy, 0);
    mreset();
    @(negedge clk);
    rstn = 1'b1; req = 4'hF; last = '0;
    step();
    chk("rst_prio", owner, 0);
    for (int c = 0; c < 3000; c++) begin
      rdp = ((c / 500) % 3) * 45;
      for (int k = 0; k < N; k++) begin
        if (req[k] && !mack[k]) begin
          if ($urandom_range(15) == 0) req[k] = 1'b0;
        end else begin
          req[k] = $urandom_range(3) != 0;
          set_word(k, 8'($urandom), $urandom_range(4) == 0);
        end
      end
      rd = $urandom_range(99) < rdp;
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
